adc_pack_axis: RTL and testbench
================================

ADC_PACK_AXIS -- requirements
Module: adc_pack_axis

Interface
REQ-001 SHALL have port adc_clk_i, input, 1 bit: single clock; all logic on its rising edge.
REQ-002 SHALL have port adc_rstn_i, input, 1 bit: reset, synchronous and active-low.
REQ-003 SHALL have port adc_a_i, input, 14 bits: channel A sample, two's complement, valid every cycle.
REQ-004 SHALL have port adc_b_i, input, 14 bits: channel B sample, two's complement, valid every cycle.
REQ-005 SHALL have port cfg_enable_i, input, 1 bit: capture enable, level.
REQ-006 SHALL have port cfg_decim_i, input, 16 bits: decimation factor N; 0 is treated as 1.
REQ-007 SHALL have port cfg_pkt_size_i, input, 32 bits: words per packet P; 0 is treated as 1.
REQ-008 SHALL have port m_axis_tdata_o, output, 64 bits: stream data.
REQ-009 SHALL have port m_axis_tvalid_o, output, 1 bit: stream valid.
REQ-010 SHALL have port m_axis_tready_i, input, 1 bit: downstream ready.
REQ-011 SHALL have port m_axis_tlast_o, output, 1 bit: last word of packet.
REQ-012 SHALL have port m_axis_tkeep_o, output, 8 bits: constant 8'hFF.
REQ-013 SHALL have port ovf_cnt_o, output, 32 bits: dropped-word count, saturating.

Function
REQ-014 SHALL take a sample pair on a decimation strobe: counter runs 0..N-1 while enabled; strobe when counter==0; counter held at 0 while disabled, so the first enabled cycle strobes.
REQ-015 SHALL pack one sample pair into 32 bits as {sext16(adc_b_i), sext16(adc_a_i)}.
REQ-016 SHALL form a word from two consecutive pairs: first pair in tdata[31:0], second in tdata[63:32].
REQ-017 Packer FSM: DIS -> LO when enabled; LO -> HI on strobe, latching the low half; HI -> LO on strobe, completing the word.
REQ-018 Packer FSM: any state -> DIS when cfg_enable_i=0; a latched low half is discarded.
REQ-019 SHALL push each completed word, with its tlast flag, into a 2-entry output buffer.
REQ-020 Head entry drives tdata/tlast; tvalid=1 iff buffer non-empty.
REQ-021 SHALL pop the head on tvalid & tready.
REQ-022 SHALL keep tdata/tlast stable while tvalid=1 and tready=0.
REQ-023 Latency: word completed at the cycle-n strobe into an empty buffer SHALL appear with tvalid=1 at cycle n+1.
REQ-024 Simultaneous push and pop on a full buffer SHALL accept the push (no drop), preserving order.
REQ-025 Push into a full buffer with no pop SHALL drop the word and increment ovf_cnt_o by 1.
REQ-026 ovf_cnt_o SHALL saturate at 32'hFFFFFFFF.
REQ-027 Dropped words SHALL NOT advance the packet counter.
REQ-028 Packet counter K counts accepted pushes; tlast=1 when K >= P-1, and K returns to 0 on that push; otherwise K increments. This covers P shrinking mid-packet; P is sampled at push time.
REQ-029 SHALL reset K to 0 while cfg_enable_i=0; already-buffered words still drain unchanged, so a truncated packet without tlast is permitted.
REQ-030 P=1 SHALL set tlast on every word.
REQ-031 cfg_decim_i changes SHALL take effect at the next counter wrap.

Reset
REQ-032 On adc_rstn_i=0 at a clock edge: buffer emptied, tvalid=0, tdata=0, tlast=0, ovf_cnt=0, K=0, decimation counter=0, FSM=DIS.
REQ-033 Reset mid-packet or mid-handshake SHALL discard all buffered and partial data without emitting tlast.
REQ-034 tkeep SHALL be 8'hFF in and out of reset.

Verification
REQ-035 N=1, P=4, tready=1, A=k, B=-k at cycle k: words {sext(-1),sext(1),0,0}..., tlast on every 4th word, first tvalid 2 cycles after enable.
REQ-036 A=14'h2000, B=14'h1FFF: low half 32'h1FFF_E000.
REQ-037 N=3: exactly one pair sampled every 3 cycles; a word every 6 cycles.
REQ-038 tready=0 for 10 cycles, N=1: buffer holds 2 words; ovf_cnt_o=3 after the stall; tdata unchanged while stalled; no tlast slip (the 4th accepted word carries tlast).
REQ-039 P changed from 8 to 2 when K=5: next accepted word has tlast=1 and K wraps to 0.
REQ-040 Enable dropped in HI state, then re-enabled: half word discarded, next word uses two fresh pairs, K restarts at 0; reset asserted while tvalid=1 clears tvalid on the next cycle.

Source files
------------

// File: rtl/adc_pack_axis.sv
// Dual-channel ADC sample packer: decimates A/B sample pairs, packs two pairs
// into one 64-bit word, and streams words through a 2-entry AXI-Stream buffer
// with packet framing (tlast) and a saturating overflow counter.
module adc_pack_axis (
    input  logic        adc_clk_i,
    input  logic        adc_rstn_i,
    input  logic [13:0] adc_a_i,
    input  logic [13:0] adc_b_i,
    input  logic        cfg_enable_i,
    input  logic [15:0] cfg_decim_i,
    input  logic [31:0] cfg_pkt_size_i,
    output logic [63:0] m_axis_tdata_o,
    output logic        m_axis_tvalid_o,
    input  logic        m_axis_tready_i,
    output logic        m_axis_tlast_o,
    output logic [7:0]  m_axis_tkeep_o,
    output logic [31:0] ovf_cnt_o
);

    typedef enum logic [1:0] {
        ST_DIS = 2'd0,
        ST_LO  = 2'd1,
        ST_HI  = 2'd2
    } state_t;

    // Sign-extend a 14-bit two's complement sample to 16 bits.
    function automatic logic [15:0] sext16(input logic [13:0] v);
        return {{2{v[13]}}, v};
    endfunction

    logic [15:0] dec_cnt_r;
    logic [15:0] dec_n_r;
    logic [15:0] n_eff_s;
    logic [15:0] n_sel_s;
    logic        strobe_s;
    state_t      state_r;
    state_t      state_next_s;
    logic        push_s;
    logic [31:0] lo_r;
    logic [31:0] pair_s;
    logic [63:0] word_s;
    logic [31:0] p_eff_s;
    logic [31:0] pk_r;
    logic        tlast_new_s;
    logic [1:0]  cnt_r;
    logic [63:0] d0_r;
    logic [63:0] d1_r;
    logic        l0_r;
    logic        l1_r;
    logic        pop_s;
    logic        full_s;
    logic        accept_s;
    logic        drop_s;
    logic [31:0] ovf_r;

    assign n_eff_s  = (cfg_decim_i == 16'd0) ? 16'd1 : cfg_decim_i;
    // A new decimation period starts at count 0 using the live factor; the
    // factor is then held for the rest of the period so changes apply at wrap.
    assign n_sel_s  = (dec_cnt_r == 16'd0) ? n_eff_s : dec_n_r;
    assign strobe_s = cfg_enable_i && (dec_cnt_r == 16'd0);
    assign pair_s   = {sext16(adc_b_i), sext16(adc_a_i)};
    assign word_s   = {pair_s, lo_r};
    assign p_eff_s  = (cfg_pkt_size_i == 32'd0) ? 32'd1 : cfg_pkt_size_i;
    assign tlast_new_s = (pk_r >= (p_eff_s - 32'd1));

    assign pop_s    = (cnt_r != 2'd0) && m_axis_tready_i;
    assign full_s   = (cnt_r == 2'd2);
    assign accept_s = push_s && (!full_s || pop_s);
    assign drop_s   = push_s && full_s && !pop_s;

    // Decimation counter: 0..N-1 while enabled, parked at 0 while disabled.
    always_ff @(posedge adc_clk_i) begin
        if (!adc_rstn_i) begin
            dec_cnt_r <= 16'd0;
            dec_n_r   <= 16'd1;
        end else if (!cfg_enable_i) begin
            dec_cnt_r <= 16'd0;
            dec_n_r   <= n_eff_s;
        end else begin
            if (dec_cnt_r == 16'd0) begin
                dec_n_r <= n_eff_s;
            end else begin
                dec_n_r <= dec_n_r;
            end
            if (dec_cnt_r >= (n_sel_s - 16'd1)) begin
                dec_cnt_r <= 16'd0;
            end else begin
                dec_cnt_r <= dec_cnt_r + 16'd1;
            end
        end
    end

    // Packer state register.
    always_ff @(posedge adc_clk_i) begin
        if (!adc_rstn_i) begin
            state_r <= ST_DIS;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Packer next state; DIS behaves like LO on the first enabled strobe.
    always_comb begin
        state_next_s = state_r;
        push_s       = 1'b0;
        if (!cfg_enable_i) begin
            state_next_s = ST_DIS;
        end else begin
            case (state_r)
                ST_DIS:  state_next_s = strobe_s ? ST_HI : ST_LO;
                ST_LO:   state_next_s = strobe_s ? ST_HI : ST_LO;
                ST_HI: begin
                    if (strobe_s) begin
                        state_next_s = ST_LO;
                        push_s       = 1'b1;
                    end else begin
                        state_next_s = ST_HI;
                    end
                end
                default: state_next_s = ST_DIS;
            endcase
        end
    end

    // Low-half latch: captures the first pair of each word.
    always_ff @(posedge adc_clk_i) begin
        if (!adc_rstn_i) begin
            lo_r <= 32'd0;
        end else if (strobe_s && (state_r != ST_HI)) begin
            lo_r <= pair_s;
        end else begin
            lo_r <= lo_r;
        end
    end

    // Packet word counter: advances only on accepted words, cleared when disabled.
    always_ff @(posedge adc_clk_i) begin
        if (!adc_rstn_i) begin
            pk_r <= 32'd0;
        end else if (!cfg_enable_i) begin
            pk_r <= 32'd0;
        end else if (accept_s) begin
            pk_r <= tlast_new_s ? 32'd0 : (pk_r + 32'd1);
        end else begin
            pk_r <= pk_r;
        end
    end

    // Two-entry output buffer; entry 0 is the head presented on the stream.
    always_ff @(posedge adc_clk_i) begin
        if (!adc_rstn_i) begin
            cnt_r <= 2'd0;
            d0_r  <= 64'd0;
            d1_r  <= 64'd0;
            l0_r  <= 1'b0;
            l1_r  <= 1'b0;
        end else begin
            case ({accept_s, pop_s})
                2'b11: begin
                    if (cnt_r == 2'd2) begin
                        d0_r <= d1_r;
                        l0_r <= l1_r;
                        d1_r <= word_s;
                        l1_r <= tlast_new_s;
                    end else begin
                        d0_r <= word_s;
                        l0_r <= tlast_new_s;
                    end
                end
                2'b10: begin
                    if (cnt_r == 2'd0) begin
                        d0_r <= word_s;
                        l0_r <= tlast_new_s;
                    end else begin
                        d1_r <= word_s;
                        l1_r <= tlast_new_s;
                    end
                    cnt_r <= cnt_r + 2'd1;
                end
                2'b01: begin
                    d0_r  <= d1_r;
                    l0_r  <= l1_r;
                    cnt_r <= cnt_r - 2'd1;
                end
                default: begin
                    cnt_r <= cnt_r;
                end
            endcase
        end
    end

    // Saturating count of words dropped because the buffer was full.
    always_ff @(posedge adc_clk_i) begin
        if (!adc_rstn_i) begin
            ovf_r <= 32'd0;
        end else if (drop_s && (ovf_r != 32'hFFFF_FFFF)) begin
            ovf_r <= ovf_r + 32'd1;
        end else begin
            ovf_r <= ovf_r;
        end
    end

    assign m_axis_tdata_o  = d0_r;
    assign m_axis_tlast_o  = l0_r;
    assign m_axis_tvalid_o = (cnt_r != 2'd0);
    assign m_axis_tkeep_o  = 8'hFF;
    assign ovf_cnt_o       = ovf_r;

endmodule

// File: tb/tb_adc_pack_axis.sv
// Directed testbench for adc_pack_axis with hand-computed expectations.
module tb_adc_pack_axis;

    logic        clk;
    logic        rstn;
    logic [13:0] adc_a;
    logic [13:0] adc_b;
    logic        enable;
    logic [15:0] decim;
    logic [31:0] pkt;
    logic [63:0] tdata;
    logic        tvalid;
    logic        tready;
    logic        tlast;
    logic [7:0]  tkeep;
    logic [31:0] ovf;

    int n_pass  = 0;
    int n_total = 0;

    adc_pack_axis dut (
        .adc_clk_i       (clk),
        .adc_rstn_i      (rstn),
        .adc_a_i         (adc_a),
        .adc_b_i         (adc_b),
        .cfg_enable_i    (enable),
        .cfg_decim_i     (decim),
        .cfg_pkt_size_i  (pkt),
        .m_axis_tdata_o  (tdata),
        .m_axis_tvalid_o (tvalid),
        .m_axis_tready_i (tready),
        .m_axis_tlast_o  (tlast),
        .m_axis_tkeep_o  (tkeep),
        .ovf_cnt_o       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total = n_total + 1;
        assert (obs === exp) n_pass = n_pass + 1;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Ramp stimulus: A = k, B = -k.
    task automatic set_smp(input int v);
        adc_a = 14'(v);
        adc_b = 14'(-v);
    endtask

    // Expected word built from pairs p and p+1 of the ramp.
    function automatic logic [63:0] mk_word(input int p);
        logic [15:0] a0, b0, a1, b1;
        a0 = 16'(p);
        b0 = 16'(-p);
        a1 = 16'(p + 1);
        b1 = 16'(-(p + 1));
        return {b1, a1, b0, a0};
    endfunction

    task automatic do_reset();
        rstn   = 1'b0;
        enable = 1'b0;
        tready = 1'b1;
        tick();
        tick();
        rstn = 1'b1;
    endtask

    initial begin
        rstn   = 1'b0;
        enable = 1'b0;
        tready = 1'b0;
        decim  = 16'd1;
        pkt    = 32'd4;
        set_smp(0);

        // Reset state
        tick();
        tick();
        check("rst_tvalid", 64'(tvalid), 64'd0);
        check("rst_tdata", tdata, 64'd0);
        check("rst_tlast", 64'(tlast), 64'd0);
        check("rst_ovf", 64'(ovf), 64'd0);
        check("rst_tkeep", 64'(tkeep), 64'hFF);
        rstn = 1'b1;
        tick();
        check("tkeep_run", 64'(tkeep), 64'hFF);

        // N=1, P=4, ramp; word every 2 cycles, tlast every 4th word
        do_reset();
        decim = 16'd1; pkt = 32'd4; tready = 1'b1;
        set_smp(0);
        enable = 1'b1;
        for (int t = 1; t <= 8; t++) begin
            tick();
            set_smp(t);
            if ((t % 2) == 0) begin
                check("ramp_tvalid", 64'(tvalid), 64'd1);
                check("ramp_tdata", tdata, mk_word(t - 2));
                check("ramp_tlast", 64'(tlast), 64'(((t / 2 - 1) % 4) == 3));
                if (t == 2) check("ramp_w0_const", tdata, 64'hFFFF_0001_0000_0000);
                if (t == 8) check("ramp_w3_const", tdata, 64'hFFF9_0007_FFFA_0006);
            end else begin
                check("ramp_idle", 64'(tvalid), 64'd0);
            end
        end

        // Sign extension, N=0 as 1, P=0 as 1
        do_reset();
        decim = 16'd0; pkt = 32'd0; tready = 1'b1;
        adc_a = 14'h2000; adc_b = 14'h1FFF;
        enable = 1'b1;
        tick();
        check("sext_first", 64'(tvalid), 64'd0);
        tick();
        check("sext_tvalid", 64'(tvalid), 64'd1);
        check("sext_low", 64'(tdata[31:0]), 64'h1FFF_E000);
        check("sext_word", tdata, 64'h1FFF_E000_1FFF_E000);
        check("p1_tlast_a", 64'(tlast), 64'd1);
        tick();
        tick();
        check("p1_tlast_b", 64'(tlast), 64'd1);

        // N=3: one pair every 3 cycles, a word every 6
        do_reset();
        decim = 16'd3; pkt = 32'd4; tready = 1'b1;
        set_smp(0);
        enable = 1'b1;
        for (int t = 1; t <= 10; t++) begin
            tick();
            set_smp(t);
            check("decim_tvalid", 64'(tvalid), 64'((t == 4) || (t == 10)));
            if (t == 4)  check("decim_w0", tdata, 64'hFFFD_0003_0000_0000);
            if (t == 10) check("decim_w1", tdata, 64'hFFF7_0009_FFFA_0006);
        end

        // Stall: buffer holds 2 words, 3 dropped, framing intact
        do_reset();
        decim = 16'd1; pkt = 32'd4; tready = 1'b0;
        set_smp(0);
        enable = 1'b1;
        for (int t = 1; t <= 11; t++) begin
            tick();
            set_smp(t);
            if (t >= 2) begin
                check("stall_tvalid", 64'(tvalid), 64'd1);
                check("stall_tdata", tdata, mk_word(0));
            end
            if (t == 10) check("stall_ovf", 64'(ovf), 64'd3);
        end
        tready = 1'b1;
        tick(); set_smp(12);
        check("drain_w1", tdata, mk_word(2));
        check("drain_w1_last", 64'(tlast), 64'd0);
        tick(); set_smp(13);
        check("drain_w5", tdata, mk_word(10));
        check("drain_w5_last", 64'(tlast), 64'd0);
        tick(); set_smp(14);
        check("drain_w6", tdata, mk_word(12));
        check("drain_w6_last", 64'(tlast), 64'd1);
        check("drain_ovf", 64'(ovf), 64'd3);

        // P shrinks from 8 to 2 with K=5
        do_reset();
        decim = 16'd1; pkt = 32'd8; tready = 1'b1;
        set_smp(0);
        enable = 1'b1;
        for (int t = 1; t <= 16; t++) begin
            tick();
            set_smp(t);
            if ((t % 2) == 0) begin
                check("pshrink_tvalid", 64'(tvalid), 64'd1);
                check("pshrink_tlast", 64'(tlast), 64'((t == 12) || (t == 16)));
            end
            if (t == 10) pkt = 32'd2;
        end

        // Enable dropped in HI, then re-enabled; then reset while tvalid=1
        do_reset();
        decim = 16'd1; pkt = 32'd2; tready = 1'b1;
        set_smp(0);
        enable = 1'b1;
        for (int t = 1; t <= 7; t++) begin
            tick();
            set_smp(t);
            if (t == 2) begin
                check("reen_w0", tdata, mk_word(0));
                check("reen_w0_last", 64'(tlast), 64'd0);
            end
            if (t == 3) enable = 1'b0;
            if ((t >= 4) && (t <= 6)) check("reen_idle", 64'(tvalid), 64'd0);
            if (t == 5) enable = 1'b1;
            if (t == 7) begin
                check("reen_tvalid", 64'(tvalid), 64'd1);
                check("reen_word", tdata, 64'hFFFA_0006_FFFB_0005);
                check("reen_k_restart", 64'(tlast), 64'd0);
            end
        end
        tready = 1'b0;
        rstn = 1'b0;
        tick();
        check("midrst_tvalid", 64'(tvalid), 64'd0);
        check("midrst_tdata", tdata, 64'd0);
        check("midrst_tlast", 64'(tlast), 64'd0);
        rstn = 1'b1;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
